sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one memory port between the fetch-stage instruction requester and the MEM-stage data requester.
//  Runs a split address/data handshake with one transaction outstanding at a time.
//  Data has priority. Instruction transactions are dropped when the WB-stage cancel fires.
//  Sits between the pipeline stages and the single-ported SRAM/bus bridge.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width; strobe width is DATA_W/8
//  STARVE_LIMIT  4   consecutive data grants tolerated while inst_req is pending (>=1); used only with the guard macro
// PORTS
//  clk           in   1         clock; all logic on posedge
//  reset         in   1         synchronous, active-high reset
//  cancel        in   1         WB-stage flush; kills pending or in-flight instruction access
//  inst_req      in   1         instruction read request
//  inst_addr     in   ADDR_W    instruction address
//  inst_addr_ok  out  1         request accepted this cycle
//  inst_data_ok  out  1         1-cycle pulse; inst_rdata valid
//  inst_rdata    out  DATA_W    registered read data
//  data_req      in   1         data request
//  data_wr       in   1         1 = write, 0 = read
//  data_wstrb    in   DATA_W/8  byte strobes; used for writes
//  data_addr     in   ADDR_W    data address
//  data_wdata    in   DATA_W    write data
//  data_addr_ok  out  1         request accepted this cycle
//  data_data_ok  out  1         1-cycle pulse; read data valid or write done
//  data_rdata    out  DATA_W    registered read data
//  mem_req       out  1         memory-side request; held until mem_addr_ok
//  mem_wr        out  1         latched write flag
//  mem_wstrb     out  DATA_W/8  latched strobes (0 for reads)
//  mem_addr      out  ADDR_W    latched address
//  mem_wdata     out  DATA_W    latched write data
//  mem_addr_ok   in   1         memory accepted the request
//  mem_data_ok   in   1         memory response valid
//  mem_rdata     in   DATA_W    memory read data
//  busy          out  1         state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. owner, drop flag and starve counter cleared.
//  - FSM has three states: IDLE, ADDR, DATA.
//  - IDLE: if a grant exists, the winner's *_addr_ok is driven combinationally high this cycle. Its fields are latched and owner is recorded. Next state ADDR.
//  - ADDR: mem_req=1 with the latched fields, which stay stable. On mem_addr_ok, go to DATA.
//  - DATA: mem_data_ok is sampled only here and ignored in any other state. On mem_data_ok, mem_rdata is registered, the owner's *_data_ok pulses the following cycle, and the FSM returns to IDLE.
//  - Back-to-back: a new grant may be issued in the same cycle as that data_ok pulse.
//  - Minimum latency: grant at T, mem_req at T+1, mem_addr_ok at T+1, mem_data_ok at T+2, data_ok at T+3.
//  - Requesters may drop req after their addr_ok. They must hold req/fields until addr_ok.
//  - Grant rule (no guard): data_req wins over inst_req. inst_addr_ok is suppressed while cancel=1.
//  - Cancel with owner=inst in ADDR or DATA: set the drop flag.
//    - The memory handshake still completes; mem_req is never withdrawn.
//    - inst_data_ok is suppressed and inst_rdata is not updated.
//    - The drop flag clears on return to IDLE.
//  - Cancel with owner=data: no effect. The data requester gates its own stores.
//  - Cancel arriving in the same cycle as mem_data_ok for owner=inst: the response is dropped.
//  - inst_data_ok and data_data_ok are never high together.
//  - Reset mid-transaction: FSM returns to IDLE and mem_req is low from the next cycle. A late mem_data_ok is ignored.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//    - Counter width is $clog2(STARVE_LIMIT+1).
//    - The counter increments on each data grant made while inst_req=1 and cancel=0.
//    - It saturates at STARVE_LIMIT and clears on any inst grant or when inst_req=0.
//    - At the limit, the next grant goes to inst even if data_req=1.
//  ARB_STARVE_GUARD_EN undefined: strict data priority; no counter logic.
// TESTING
//  1. Inst read to 0x0000_1000; memory gives addr_ok at +0 and data_ok at +1 with 0xDEADBEEF -> inst_data_ok 3 cycles after grant, inst_rdata=0xDEADBEEF.
//  2. inst_req and data_req (write, wstrb=0xF, 0x2000, 0x12345678) in the same cycle -> data_addr_ok, mem_wr=1, then data_data_ok; inst is granted in the following IDLE.
//  3. Inst in DATA state, cancel pulses for one cycle, then mem_data_ok with 0xCAFE0000 -> no inst_data_ok; FSM back in IDLE, busy=0.
//  4. mem_addr_ok held low for 5 cycles -> mem_req and mem_addr/mem_wdata stable all 5 cycles; no addr_ok rework.
//  5. Guard on, STARVE_LIMIT=4, data_req and inst_req both held -> grants are data x4, then inst, then data. Guard off -> data only.
//  6. Reset asserted in DATA state, then mem_data_ok arrives -> no data_ok pulse; all outputs 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one split address/data memory port between the instruction and data requesters.
// Define ARB_STARVE_GUARD_EN to bound consecutive data grants while an instruction fetch waits.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cancel,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int SW = DATA_W/8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;
  typedef struct packed {
    logic              wr;
    logic [SW-1:0]     wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  state_t state, state_nxt;
  owner_t owner;
  mreq_t  mreq;
  logic   drop, inst_gnt, data_gnt, starve;
  logic   rsp, inst_deliver, data_deliver;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT+1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt;

  assign starve = (starve_cnt == LIM);

  always_ff @(posedge clk) begin
    if (reset)                           starve_cnt <= '0;
    else if (!inst_req || inst_gnt)      starve_cnt <= '0;
    else if (data_gnt && !cancel && !starve) starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign starve = 1'b0;
`endif

  // Grants only happen in IDLE; a cancelled fetch is never accepted.
  always_comb begin
    inst_gnt  = 1'b0;
    data_gnt  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (!reset) begin
        if (inst_req && !cancel && (starve || !data_req)) begin
          inst_gnt  = 1'b1;
          state_nxt = ADDR;
        end else if (data_req) begin
          data_gnt  = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR:    if (mem_addr_ok) state_nxt = DATA;
      DATA:    if (mem_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign inst_addr_ok = inst_gnt;
  assign data_addr_ok = data_gnt;
  assign mem_req      = (state == ADDR);
  assign mem_wr       = mreq.wr;
  assign mem_wstrb    = mreq.wstrb;
  assign mem_addr     = mreq.addr;
  assign mem_wdata    = mreq.wdata;
  assign busy         = (state != IDLE);

  // A cancel landing with the response still kills the fetch.
  assign rsp          = (state == DATA) && mem_data_ok;
  assign inst_deliver = rsp && (owner == OWN_INST) && !drop && !cancel;
  assign data_deliver = rsp && (owner == OWN_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= OWN_INST;
      drop         <= 1'b0;
      mreq         <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      state        <= state_nxt;
      inst_data_ok <= inst_deliver;
      data_data_ok <= data_deliver;
      if (inst_deliver) inst_rdata <= mem_rdata;
      if (data_deliver) data_rdata <= mem_rdata;
      if (inst_gnt) begin
        owner       <= OWN_INST;
        mreq.wr     <= 1'b0;
        mreq.wstrb  <= '0;
        mreq.addr   <= inst_addr;
        mreq.wdata  <= '0;
      end else if (data_gnt) begin
        owner       <= OWN_DATA;
        mreq.wr     <= data_wr;
        mreq.wstrb  <= data_wr ? data_wstrb : '0;
        mreq.addr   <= data_addr;
        mreq.wdata  <= data_wdata;
      end
      if (state_nxt == IDLE)
        drop <= 1'b0;
      else if (cancel && owner == OWN_INST && state != IDLE)
        drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter; responses are checked against a scoreboard queue.
module tb_sram_port_arbiter;
  logic        clk = 1'b0;
  logic        reset, cancel;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy;

  typedef struct {
    logic        is_inst;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .cancel(cancel),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_inst, input logic chk_rd, input logic [31:0] rd);
    exp_t e;
    e.is_inst = is_inst;
    e.chk_rd  = chk_rd;
    e.rd      = rd;
    sb.push_back(e);
  endtask

  // Called in the first ADDR cycle; returns in the IDLE cycle carrying the data_ok pulse.
  task automatic run_mem(input int aw, input int dw, input logic [31:0] rd,
                         input logic [31:0] ea, input logic [31:0] ew);
    for (int i = 0; i < aw; i++) begin
      mem_addr_ok = 1'b0;
      #1;
      chk("hold_mem_req", mem_req, 1);
      chk("hold_mem_addr", mem_addr, ea);
      chk("hold_mem_wdata", mem_wdata, ew);
      step();
    end
    mem_addr_ok = 1'b1;
    #1;
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, ea);
    step();
    mem_addr_ok = 1'b0;
    for (int i = 0; i < dw; i++) step();
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    step();
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    #1;
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (inst_data_ok || data_data_ok) begin
      exp_t e;
      chk("data_ok_onehot", inst_data_ok & data_data_ok, 0);
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_owner_inst", inst_data_ok, e.is_inst);
        if (e.chk_rd) chk("rsp_rdata", e.is_inst ? inst_rdata : data_rdata, e.rd);
      end
    end
  end

  initial begin
    logic exp_inst;
    reset = 1'b1; cancel = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    reset = 1'b0;
    step();

    // 1: single instruction read, minimum latency
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    #1;
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    step();
    inst_req = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_mem_wr", {mem_wr, mem_wstrb}, 0);
    run_mem(0, 0, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0);
    chk("t1_inst_data_ok_T3", inst_data_ok, 1);
    step();
    chk("t1_pulse_width", inst_data_ok, 0);

    // 2+4: simultaneous requests, data write wins; addr_ok stalled 5 cycles
    inst_req = 1'b1; inst_addr = 32'h0000_1004;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h0000_2000; data_wdata = 32'h1234_5678;
    #1;
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok", inst_addr_ok, 0);
    push(1'b0, 1'b0, 32'h0);
    step();
    data_req = 1'b0;
    chk("t2_mem_wr", mem_wr, 1);
    chk("t2_mem_wstrb", mem_wstrb, 4'hF);
    chk("t2_no_inst_grant_busy", inst_addr_ok, 0);
    run_mem(5, 0, 32'h0, 32'h0000_2000, 32'h1234_5678);
    chk("t2_data_data_ok", data_data_ok, 1);
    chk("t2_b2b_inst_grant", inst_addr_ok, 1);
    push(1'b1, 1'b1, 32'h1111_0000);
    step();
    inst_req = 1'b0;
    chk("t2_inst_mem_addr", mem_addr, 32'h0000_1004);
    run_mem(0, 1, 32'h1111_0000, 32'h0000_1004, 32'h0);
    step();

    // cancel in IDLE blocks the instruction grant
    inst_req = 1'b1; inst_addr = 32'h0000_3000; cancel = 1'b1;
    #1;
    chk("cancel_idle_addr_ok", inst_addr_ok, 0);
    step();
    chk("cancel_idle_busy", busy, 0);
    cancel = 1'b0;

    // 3: cancel pulse while instruction is in DATA
    #1;
    chk("t3_inst_addr_ok", inst_addr_ok, 1);
    step();
    inst_req = 1'b0;
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("t3_busy_mid", busy, 1);
    mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0000;
    step();
    mem_data_ok = 1'b0;
    chk("t3_no_inst_data_ok", inst_data_ok, 0);
    chk("t3_busy", busy, 0);
    chk("t3_rdata_kept", inst_rdata, 32'h1111_0000);

    // cancel coinciding with the response
    inst_req = 1'b1; inst_addr = 32'h0000_3004;
    step();
    inst_req = 1'b0;
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_0BAD; cancel = 1'b1;
    step();
    mem_data_ok = 1'b0; cancel = 1'b0;
    chk("t3b_no_inst_data_ok", inst_data_ok, 0);
    chk("t3b_rdata_kept", inst_rdata, 32'h1111_0000);

    // 5: both requesters held
    inst_req = 1'b1; inst_addr = 32'h0000_5000;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h0000_6000;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_inst = (i == 4);
`else
      exp_inst = 1'b0;
`endif
      #1;
      chk("t5_inst_grant", inst_addr_ok, exp_inst);
      chk("t5_data_grant", data_addr_ok, !exp_inst);
      push(exp_inst, 1'b1, 32'hA0 + 32'(i));
      step();
      chk("t5_read_wstrb", mem_wstrb, 0);
      run_mem(0, 0, 32'hA0 + 32'(i), exp_inst ? 32'h0000_5000 : 32'h0000_6000, 32'h0);
    end
    inst_req = 1'b0; data_req = 1'b0;
    step();

    // 6: reset in DATA, late response ignored
    data_req = 1'b1; data_addr = 32'h0000_4000;
    step();
    data_req = 1'b0;
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_mem_req", mem_req, 0);
    step();
    mem_data_ok = 1'b0;
    chk("t6_no_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("t6_data_rdata", data_rdata, 0);
    chk("t6_mem_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, 0);
    step();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
